// File: rtl/ysyx_24100029_xbar.sv
// AXI4 1-to-2 crossbar: CPU master port to CLINT (read-only) and SoC bus.
// Independent read and write FSMs; CLINT writes are answered locally with SLVERR.
module ysyx_24100029_xbar #(
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_araddr,
  input  logic        in_arvalid,
  input  logic [3:0]  in_arid,
  input  logic [7:0]  in_arlen,
  input  logic [2:0]  in_arsize,
  input  logic [1:0]  in_arburst,
  output logic        in_arready,
  output logic [31:0] in_rdata,
  output logic [1:0]  in_rresp,
  output logic        in_rvalid,
  output logic        in_rlast,
  output logic [3:0]  in_rid,
  input  logic        in_rready,
  input  logic [31:0] in_awaddr,
  input  logic        in_awvalid,
  input  logic [3:0]  in_awid,
  input  logic [7:0]  in_awlen,
  input  logic [2:0]  in_awsize,
  input  logic [1:0]  in_awburst,
  output logic        in_awready,
  input  logic [31:0] in_wdata,
  input  logic [3:0]  in_wstrb,
  input  logic        in_wvalid,
  input  logic        in_wlast,
  output logic        in_wready,
  output logic [1:0]  in_bresp,
  output logic        in_bvalid,
  output logic [3:0]  in_bid,
  input  logic        in_bready,
  output logic [31:0] clint_araddr,
  output logic        clint_arvalid,
  output logic [3:0]  clint_arid,
  output logic [7:0]  clint_arlen,
  output logic [2:0]  clint_arsize,
  output logic [1:0]  clint_arburst,
  input  logic        clint_arready,
  input  logic [31:0] clint_rdata,
  input  logic [1:0]  clint_rresp,
  input  logic        clint_rvalid,
  input  logic        clint_rlast,
  input  logic [3:0]  clint_rid,
  output logic        clint_rready,
  output logic [31:0] soc_araddr,
  output logic        soc_arvalid,
  output logic [3:0]  soc_arid,
  output logic [7:0]  soc_arlen,
  output logic [2:0]  soc_arsize,
  output logic [1:0]  soc_arburst,
  input  logic        soc_arready,
  input  logic [31:0] soc_rdata,
  input  logic [1:0]  soc_rresp,
  input  logic        soc_rvalid,
  input  logic        soc_rlast,
  input  logic [3:0]  soc_rid,
  output logic        soc_rready,
  output logic [31:0] soc_awaddr,
  output logic        soc_awvalid,
  output logic [3:0]  soc_awid,
  output logic [7:0]  soc_awlen,
  output logic [2:0]  soc_awsize,
  output logic [1:0]  soc_awburst,
  input  logic        soc_awready,
  output logic [31:0] soc_wdata,
  output logic [3:0]  soc_wstrb,
  output logic        soc_wvalid,
  output logic        soc_wlast,
  input  logic        soc_wready,
  input  logic [1:0]  soc_bresp,
  input  logic        soc_bvalid,
  input  logic [3:0]  soc_bid,
  output logic        soc_bready,
  output logic [1:0]  dbg_rd_state_o,
  output logic [1:0]  dbg_wr_state_o
);

  // Handshakes: a beat transfers in the cycle where valid and ready are both 1;
  // valid never depends on ready, and payload holds while valid is 1 and ready is 0.
  typedef enum logic [1:0] {R_IDLE, R_CLINT, R_SOC} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_SOC, W_ERR_DATA, W_ERR_RESP} wr_state_e;

  rd_state_e   rd_q, rd_d;
  wr_state_e   wr_q, wr_d;
  logic [31:0] raddr_q, raddr_d;
  logic [3:0]  rid_q, rid_d;
  logic [3:0]  bid_q, bid_d;
  logic        ar_hit, aw_hit;
  logic        unused_ok;

  assign ar_hit = (in_araddr & CLINT_MASK) == CLINT_BASE;
  assign aw_hit = (in_awaddr & CLINT_MASK) == CLINT_BASE;
  // CLINT accepts the level request whenever it likes; only its R beat matters.
  assign unused_ok = ^{clint_arready, clint_rlast, clint_rid};
  assign dbg_rd_state_o = rd_q;
  assign dbg_wr_state_o = wr_q;

  always_comb begin
    rd_d = rd_q;
    raddr_d = raddr_q;
    rid_d = rid_q;
    in_arready = 1'b0;
    in_rdata = '0;
    in_rresp = '0;
    in_rvalid = 1'b0;
    in_rlast = 1'b0;
    in_rid = '0;
    clint_araddr = '0;
    clint_arvalid = 1'b0;
    clint_arid = '0;
    clint_arlen = '0;
    clint_arsize = '0;
    clint_arburst = '0;
    clint_rready = 1'b0;
    soc_araddr = '0;
    soc_arvalid = 1'b0;
    soc_arid = '0;
    soc_arlen = '0;
    soc_arsize = '0;
    soc_arburst = '0;
    soc_rready = 1'b0;
    if (!reset) begin
      case (rd_q)
        R_IDLE: begin
          if (ar_hit) begin
            in_arready = 1'b1;
            if (in_arvalid) begin
              raddr_d = in_araddr;
              rid_d = in_arid;
              rd_d = R_CLINT;
            end
          end else begin
            soc_araddr = in_araddr;
            soc_arvalid = in_arvalid;
            soc_arid = in_arid;
            soc_arlen = in_arlen;
            soc_arsize = in_arsize;
            soc_arburst = in_arburst;
            in_arready = soc_arready;
            if (in_arvalid && soc_arready) rd_d = R_SOC;
          end
        end
        R_CLINT: begin
          clint_araddr = raddr_q;
          clint_arvalid = 1'b1;
          clint_arid = rid_q;
          clint_arsize = 3'd2;
          clint_arburst = 2'b01;
          clint_rready = in_rready;
          in_rvalid = clint_rvalid;
          in_rdata = clint_rdata;
          in_rresp = clint_rresp;
          in_rlast = 1'b1;
          in_rid = rid_q;
          if (clint_rvalid && in_rready) rd_d = R_IDLE;
        end
        R_SOC: begin
          in_rvalid = soc_rvalid;
          in_rdata = soc_rdata;
          in_rresp = soc_rresp;
          in_rlast = soc_rlast;
          in_rid = soc_rid;
          soc_rready = in_rready;
          if (soc_rvalid && in_rready && soc_rlast) rd_d = R_IDLE;
        end
        default: rd_d = R_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_d = wr_q;
    bid_d = bid_q;
    in_awready = 1'b0;
    in_wready = 1'b0;
    in_bresp = '0;
    in_bvalid = 1'b0;
    in_bid = '0;
    soc_awaddr = '0;
    soc_awvalid = 1'b0;
    soc_awid = '0;
    soc_awlen = '0;
    soc_awsize = '0;
    soc_awburst = '0;
    soc_wdata = '0;
    soc_wstrb = '0;
    soc_wvalid = 1'b0;
    soc_wlast = 1'b0;
    soc_bready = 1'b0;
    if (!reset) begin
      case (wr_q)
        W_IDLE: begin
          if (aw_hit) begin
            in_awready = 1'b1;
            if (in_awvalid) begin
              bid_d = in_awid;
              wr_d = W_ERR_DATA;
            end
          end else begin
            soc_awaddr = in_awaddr;
            soc_awvalid = in_awvalid;
            soc_awid = in_awid;
            soc_awlen = in_awlen;
            soc_awsize = in_awsize;
            soc_awburst = in_awburst;
            in_awready = soc_awready;
            if (in_awvalid && soc_awready) wr_d = W_SOC;
          end
        end
        W_SOC: begin
          soc_wdata = in_wdata;
          soc_wstrb = in_wstrb;
          soc_wvalid = in_wvalid;
          soc_wlast = in_wlast;
          in_wready = soc_wready;
          in_bvalid = soc_bvalid;
          in_bresp = soc_bresp;
          in_bid = soc_bid;
          soc_bready = in_bready;
          if (soc_bvalid && in_bready) wr_d = W_IDLE;
        end
        W_ERR_DATA: begin
          // CLINT is read-only: swallow the data beats, then report SLVERR.
          in_wready = 1'b1;
          if (in_wvalid && in_wlast) wr_d = W_ERR_RESP;
        end
        W_ERR_RESP: begin
          in_bvalid = 1'b1;
          in_bresp = 2'b10;
          in_bid = bid_q;
          if (in_bready) wr_d = W_IDLE;
        end
        default: wr_d = W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q <= R_IDLE;
      wr_q <= W_IDLE;
      raddr_q <= '0;
      rid_q <= '0;
      bid_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      raddr_q <= raddr_d;
      rid_q <= rid_d;
      bid_q <= bid_d;
    end
  end

endmodule
